// File: rtl/mem_noc_req_xbar.sv
// N-master to M-slave AW/W/AR request crossbar: address-interleave routing, per-slave round-robin, 2-entry slave buffers.
// Optional per-slave handshake counters are enabled with MEM_NOC_REQ_XBAR_PERF_EN.

module mem_noc_req_xbar_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  // Full/empty come from the pre-update count, so push and pop may coincide.
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

module mem_noc_req_xbar #(
  parameter int unsigned NUM_MASTERS    = 5,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned AW_WIDTH       = 64,
  parameter int unsigned W_WIDTH        = 80,
  parameter int unsigned AR_WIDTH       = 64,
  parameter int unsigned ADDR_POS       = 0,
  parameter int unsigned SEL_LSB        = 6,
  parameter int unsigned WLAST_POSITION = 0,
  parameter int unsigned WROUTE_DEPTH   = 4,
  parameter int unsigned WORDER_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_MASTERS-1:0]         m_awvalid,
  output logic [NUM_MASTERS-1:0]         m_awready,
  input  logic [NUM_MASTERS*AW_WIDTH-1:0] m_aw,
  input  logic [NUM_MASTERS-1:0]         m_wvalid,
  output logic [NUM_MASTERS-1:0]         m_wready,
  input  logic [NUM_MASTERS*W_WIDTH-1:0] m_w,
  input  logic [NUM_MASTERS-1:0]         m_arvalid,
  output logic [NUM_MASTERS-1:0]         m_arready,
  input  logic [NUM_MASTERS*AR_WIDTH-1:0] m_ar,
  output logic [NUM_SLAVES-1:0]          s_awvalid,
  input  logic [NUM_SLAVES-1:0]          s_awready,
  output logic [NUM_SLAVES*AW_WIDTH-1:0] s_aw,
  output logic [NUM_SLAVES-1:0]          s_wvalid,
  input  logic [NUM_SLAVES-1:0]          s_wready,
  output logic [NUM_SLAVES*W_WIDTH-1:0]  s_w,
  output logic [NUM_SLAVES-1:0]          s_arvalid,
  input  logic [NUM_SLAVES-1:0]          s_arready,
  output logic [NUM_SLAVES*AR_WIDTH-1:0] s_ar,
  output logic                           clk_en
`ifdef MEM_NOC_REQ_XBAR_PERF_EN
  ,
  output logic [NUM_SLAVES*32-1:0]       perf_aw_cnt,
  output logic [NUM_SLAVES*32-1:0]       perf_ar_cnt
`endif
);
  localparam int unsigned SW = $clog2(NUM_SLAVES);
  localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [SW-1:0]          aw_sel [NUM_MASTERS];
  logic [SW-1:0]          ar_sel [NUM_MASTERS];
  logic [MW-1:0]          rr_aw_q [NUM_SLAVES];
  logic [MW-1:0]          rr_aw_d [NUM_SLAVES];
  logic [MW-1:0]          rr_ar_q [NUM_SLAVES];
  logic [MW-1:0]          rr_ar_d [NUM_SLAVES];

  logic [NUM_MASTERS-1:0] wroute_push, wroute_pop, wroute_full, wroute_empty;
  logic [SW-1:0]          wroute_din  [NUM_MASTERS];
  logic [SW-1:0]          wroute_head [NUM_MASTERS];
  logic [NUM_SLAVES-1:0]  worder_push, worder_pop, worder_full, worder_empty;
  logic [MW-1:0]          worder_din  [NUM_SLAVES];
  logic [MW-1:0]          worder_head [NUM_SLAVES];

  logic [NUM_SLAVES-1:0]  aw_push, aw_pop, aw_full, aw_empty;
  logic [NUM_SLAVES-1:0]  w_push,  w_pop,  w_full,  w_empty;
  logic [NUM_SLAVES-1:0]  ar_push, ar_pop, ar_full, ar_empty;
  logic [AW_WIDTH-1:0]    aw_din [NUM_SLAVES];
  logic [W_WIDTH-1:0]     w_din  [NUM_SLAVES];
  logic [AR_WIDTH-1:0]    ar_din [NUM_SLAVES];

  // Fold an out-of-range select back into the slave range (one subtract suffices).
  function automatic logic [SW-1:0] sel_of(input logic [SW-1:0] raw);
    if ({1'b0, raw} >= (SW+1)'(NUM_SLAVES)) return raw - SW'(NUM_SLAVES);
    return raw;
  endfunction

  // Round-robin pick starting at ptr; returns a one-hot grant.
  function automatic logic [NUM_MASTERS-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [MW-1:0] ptr);
    logic [NUM_MASTERS-1:0] g;
    logic                   found;
    int unsigned            idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[MW'(idx)]) begin
        g[MW'(idx)] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

  // AW arbitration: also books the W route (master side) and W order (slave side).
  always_comb begin
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt;
    m_awready   = '0;
    aw_push     = '0;
    worder_push = '0;
    wroute_push = '0;
    rr_aw_d     = rr_aw_q;
    req         = '0;
    gnt         = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      aw_sel[m]     = sel_of(m_aw[m*AW_WIDTH + ADDR_POS + SEL_LSB +: SW]);
      wroute_din[m] = '0;
    end
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      aw_din[s]     = '0;
      worder_din[s] = '0;
    end
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      for (int unsigned m = 0; m < NUM_MASTERS; m++)
        req[m] = m_awvalid[m] & (aw_sel[m] == SW'(s)) & ~wroute_full[m];
      if (!rstn || worder_full[s] || aw_full[s]) req = '0;
      gnt = rr_pick(req, rr_aw_q[s]);
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        if (gnt[m]) begin
          m_awready[m]   = 1'b1;
          aw_push[s]     = 1'b1;
          aw_din[s]      = m_aw[m*AW_WIDTH +: AW_WIDTH];
          worder_push[s] = 1'b1;
          worder_din[s]  = MW'(m);
          wroute_push[m] = 1'b1;
          wroute_din[m]  = SW'(s);
          rr_aw_d[s]     = (m == NUM_MASTERS - 1) ? '0 : MW'(m + 1);
        end
      end
    end
  end

  // W steering: a master may send only when it heads both its route and the slave's order queue.
  always_comb begin
    logic [SW-1:0] d;
    logic          elig;
    m_wready   = '0;
    w_push     = '0;
    wroute_pop = '0;
    worder_pop = '0;
    d          = '0;
    elig       = 1'b0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) w_din[s] = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      d    = wroute_head[m];
      elig = rstn & ~wroute_empty[m] & ~worder_empty[d] &
             (worder_head[d] == MW'(m)) & ~w_full[d];
      m_wready[m] = elig;
      if (elig && m_wvalid[m]) begin
        w_push[d] = 1'b1;
        w_din[d]  = m_w[m*W_WIDTH +: W_WIDTH];
        if (m_w[m*W_WIDTH + WLAST_POSITION]) begin
          wroute_pop[m] = 1'b1;
          worder_pop[d] = 1'b1;
        end
      end
    end
  end

  // AR arbitration carries no ordering state.
  always_comb begin
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt;
    m_arready = '0;
    ar_push   = '0;
    rr_ar_d   = rr_ar_q;
    req       = '0;
    gnt       = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++)
      ar_sel[m] = sel_of(m_ar[m*AR_WIDTH + ADDR_POS + SEL_LSB +: SW]);
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      ar_din[s] = '0;
      for (int unsigned m = 0; m < NUM_MASTERS; m++)
        req[m] = m_arvalid[m] & (ar_sel[m] == SW'(s));
      if (!rstn || ar_full[s]) req = '0;
      gnt = rr_pick(req, rr_ar_q[s]);
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        if (gnt[m]) begin
          m_arready[m] = 1'b1;
          ar_push[s]   = 1'b1;
          ar_din[s]    = m_ar[m*AR_WIDTH +: AR_WIDTH];
          rr_ar_d[s]   = (m == NUM_MASTERS - 1) ? '0 : MW'(m + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        rr_aw_q[s] <= '0;
        rr_ar_q[s] <= '0;
      end
    end else begin
      rr_aw_q <= rr_aw_d;
      rr_ar_q <= rr_ar_d;
    end
  end

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_mst
    mem_noc_req_xbar_fifo #(.WIDTH(SW), .DEPTH(WROUTE_DEPTH)) u_wroute (
      .clk, .rstn, .push_i(wroute_push[m]), .pop_i(wroute_pop[m]), .data_i(wroute_din[m]),
      .data_o(wroute_head[m]), .full_o(wroute_full[m]), .empty_o(wroute_empty[m]));
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
    mem_noc_req_xbar_fifo #(.WIDTH(MW), .DEPTH(WORDER_DEPTH)) u_worder (
      .clk, .rstn, .push_i(worder_push[s]), .pop_i(worder_pop[s]), .data_i(worder_din[s]),
      .data_o(worder_head[s]), .full_o(worder_full[s]), .empty_o(worder_empty[s]));
    mem_noc_req_xbar_fifo #(.WIDTH(AW_WIDTH), .DEPTH(2)) u_aw (
      .clk, .rstn, .push_i(aw_push[s]), .pop_i(aw_pop[s]), .data_i(aw_din[s]),
      .data_o(s_aw[s*AW_WIDTH +: AW_WIDTH]), .full_o(aw_full[s]), .empty_o(aw_empty[s]));
    mem_noc_req_xbar_fifo #(.WIDTH(W_WIDTH), .DEPTH(2)) u_w (
      .clk, .rstn, .push_i(w_push[s]), .pop_i(w_pop[s]), .data_i(w_din[s]),
      .data_o(s_w[s*W_WIDTH +: W_WIDTH]), .full_o(w_full[s]), .empty_o(w_empty[s]));
    mem_noc_req_xbar_fifo #(.WIDTH(AR_WIDTH), .DEPTH(2)) u_ar (
      .clk, .rstn, .push_i(ar_push[s]), .pop_i(ar_pop[s]), .data_i(ar_din[s]),
      .data_o(s_ar[s*AR_WIDTH +: AR_WIDTH]), .full_o(ar_full[s]), .empty_o(ar_empty[s]));

    assign s_awvalid[s] = ~aw_empty[s];
    assign s_wvalid[s]  = ~w_empty[s];
    assign s_arvalid[s] = ~ar_empty[s];
    assign aw_pop[s]    = s_awvalid[s] & s_awready[s];
    assign w_pop[s]     = s_wvalid[s] & s_wready[s];
    assign ar_pop[s]    = s_arvalid[s] & s_arready[s];
  end

  assign clk_en = (|m_awvalid) | (|m_wvalid) | (|m_arvalid) |
                  ~(&aw_empty) | ~(&w_empty) | ~(&ar_empty) |
                  ~(&wroute_empty) | ~(&worder_empty);

`ifdef MEM_NOC_REQ_XBAR_PERF_EN
  logic [31:0] perf_aw_q [NUM_SLAVES];
  logic [31:0] perf_ar_q [NUM_SLAVES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        perf_aw_q[s] <= '0;
        perf_ar_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        if (aw_pop[s]) perf_aw_q[s] <= perf_aw_q[s] + 32'd1;
        if (ar_pop[s]) perf_ar_q[s] <= perf_ar_q[s] + 32'd1;
      end
    end
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_perf
    assign perf_aw_cnt[s*32 +: 32] = perf_aw_q[s];
    assign perf_ar_cnt[s*32 +: 32] = perf_ar_q[s];
  end
`endif
endmodule

// File: tb/tb_mem_noc_req_xbar.sv
// Directed bench for mem_noc_req_xbar with a per-slave, per-channel expected-payload scoreboard.
module tb_mem_noc_req_xbar;
  localparam int NM = 5;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NM-1:0]   m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready;
  logic [NM*64-1:0] m_aw, m_ar;
  logic [NM*80-1:0] m_w;
  logic [NS-1:0]   s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
  logic [NS*64-1:0] s_aw, s_ar;
  logic [NS*80-1:0] s_w;
  logic            clk_en;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_aw [NS][$];
  logic [79:0] exp_w  [NS][$];
  logic [63:0] exp_ar [NS][$];

  always #5 clk = ~clk;

  mem_noc_req_xbar dut (
    .clk(clk), .rstn(rstn),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
    .clk_en(clk_en));

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] awpl(input int m, input logic [47:0] addr);
    return {8'hA0, 8'(m), addr};
  endfunction

  function automatic logic [63:0] arpl(input int m, input logic [47:0] addr);
    return {8'hB0, 8'(m), addr};
  endfunction

  function automatic logic [79:0] wpl(input int m, input int b, input logic last);
    return {16'(m), 16'(b), 47'h0, last};
  endfunction

  // Slave-side scoreboard: every slave handshake must match the oldest expected payload.
  always @(negedge clk) begin
    if (rstn) begin
      for (int s = 0; s < NS; s++) begin
        if (s_awvalid[s] && s_awready[s]) begin
          chk("s_aw_expected_present", 80'(exp_aw[s].size() != 0), 80'(1));
          if (exp_aw[s].size() != 0) chk("s_aw_payload", 80'(s_aw[s*64 +: 64]), 80'(exp_aw[s].pop_front()));
        end
        if (s_wvalid[s] && s_wready[s]) begin
          chk("s_w_expected_present", 80'(exp_w[s].size() != 0), 80'(1));
          if (exp_w[s].size() != 0) chk("s_w_payload", s_w[s*80 +: 80], exp_w[s].pop_front());
        end
        if (s_arvalid[s] && s_arready[s]) begin
          chk("s_ar_expected_present", 80'(exp_ar[s].size() != 0), 80'(1));
          if (exp_ar[s].size() != 0) chk("s_ar_payload", 80'(s_ar[s*64 +: 64]), 80'(exp_ar[s].pop_front()));
        end
      end
    end
  end

  task automatic wait_rdy(input int ch, input int m, input string tag);
    int   n = 0;
    logic r = 1'b0;
    do begin
      @(negedge clk);
      r = (ch == 0) ? m_awready[m] : (ch == 1) ? m_wready[m] : m_arready[m];
      n++;
    end while (!r && n < 64);
    chk(tag, 80'(r), 80'(1));
  endtask

  task automatic aw_send(input int m, input logic [47:0] addr);
    logic [63:0] pl = awpl(m, addr);
    m_awvalid[m] = 1'b1;
    m_aw[m*64 +: 64] = pl;
    exp_aw[addr[6]].push_back(pl);
    wait_rdy(0, m, "aw_handshake");
    @(posedge clk); #1;
    m_awvalid[m] = 1'b0;
  endtask

  task automatic w_beat(input int m, input logic [79:0] pl);
    m_wvalid[m] = 1'b1;
    m_w[m*80 +: 80] = pl;
    wait_rdy(1, m, "w_handshake");
    @(posedge clk); #1;
    m_wvalid[m] = 1'b0;
  endtask

  task automatic w_burst(input int m, input int n);
    for (int b = 0; b < n; b++) w_beat(m, wpl(m, b, b == n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    m_aw = '0; m_w = '0; m_ar = '0;
    s_awready = '1; s_wready = '1; s_arready = '1;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_s_awvalid", 80'(s_awvalid), 80'(0));
    chk("rst_s_wvalid", 80'(s_wvalid), 80'(0));
    chk("rst_s_arvalid", 80'(s_arvalid), 80'(0));
    m_awvalid = '1; m_arvalid = '1;
    #1;
    chk("rst_m_awready", 80'(m_awready), 80'(0));
    chk("rst_m_arready", 80'(m_arready), 80'(0));
    m_awvalid = '0; m_arvalid = '0;
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_clk_en", 80'(clk_en), 80'(0));
    @(posedge clk); #1;

    // Test 1: master 0, one AW to slave 1, 4-beat burst
    m_awvalid[0] = 1'b1;
    m_aw[0 +: 64] = awpl(0, 48'h40);
    exp_aw[1].push_back(awpl(0, 48'h40));
    @(negedge clk);
    chk("t1_awready", 80'(m_awready[0]), 80'(1));
    chk("t1_clk_en", 80'(clk_en), 80'(1));
    chk("t1_s_awvalid_before", 80'(s_awvalid[1]), 80'(0));
    @(posedge clk); #1;
    m_awvalid[0] = 1'b0;
    @(negedge clk);
    chk("t1_s_awvalid_after", 80'(s_awvalid[1]), 80'(1));
    chk("t1_s_awvalid_slave0", 80'(s_awvalid[0]), 80'(0));
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) exp_w[1].push_back(wpl(0, b, b == 3));
    w_burst(0, 4);

    // Test 2: masters 1 and 3 to slave 0 in the same cycle
    m_awvalid[1] = 1'b1; m_aw[64 +: 64]  = awpl(1, 48'h00);
    m_awvalid[3] = 1'b1; m_aw[192 +: 64] = awpl(3, 48'h80);
    exp_aw[0].push_back(awpl(1, 48'h00));
    exp_aw[0].push_back(awpl(3, 48'h80));
    @(negedge clk);
    chk("t2_first_grant_m1", 80'(m_awready[1]), 80'(1));
    chk("t2_first_hold_m3", 80'(m_awready[3]), 80'(0));
    @(posedge clk); #1;
    m_awvalid[1] = 1'b0;
    @(negedge clk);
    chk("t2_second_grant_m3", 80'(m_awready[3]), 80'(1));
    @(posedge clk); #1;
    m_awvalid[3] = 1'b0;
    for (int b = 0; b < 2; b++) exp_w[0].push_back(wpl(1, b, b == 1));
    for (int b = 0; b < 2; b++) exp_w[0].push_back(wpl(3, b, b == 1));
    fork
      w_burst(3, 2);
      w_burst(1, 2);
    join

    // Test 3: master 2 presents W before its AW
    m_wvalid[2] = 1'b1;
    m_w[160 +: 80] = wpl(2, 0, 1'b1);
    exp_w[1].push_back(wpl(2, 0, 1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_wready_held", 80'(m_wready[2]), 80'(0));
    end
    @(posedge clk); #1;
    aw_send(2, 48'h40);
    wait_rdy(1, 2, "t3_w_after_aw");
    @(posedge clk); #1;
    m_wvalid[2] = 1'b0;

    // Test 4: W route FIFO depth limits outstanding AWs
    s_wready[1] = 1'b0;
    for (int i = 0; i < 4; i++) aw_send(0, 48'(32'h40 + i * 32'h80));
    m_awvalid[0] = 1'b1;
    m_aw[0 +: 64] = awpl(0, 48'h240);
    exp_aw[1].push_back(awpl(0, 48'h240));
    for (int i = 0; i < 5; i++) exp_w[1].push_back(wpl(0, 16 + i, 1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_aw5_blocked", 80'(m_awready[0]), 80'(0));
    end
    @(posedge clk); #1;
    m_wvalid[0] = 1'b1;
    m_w[0 +: 80] = wpl(0, 16, 1'b1);
    @(negedge clk);
    chk("t4_first_wlast_ready", 80'(m_wready[0]), 80'(1));
    chk("t4_aw5_blocked_same_cycle", 80'(m_awready[0]), 80'(0));
    @(posedge clk); #1;
    m_wvalid[0] = 1'b0;
    @(negedge clk);
    chk("t4_aw5_released", 80'(m_awready[0]), 80'(1));
    @(posedge clk); #1;
    m_awvalid[0] = 1'b0;
    s_wready[1] = 1'b1;
    for (int i = 1; i < 5; i++) w_beat(0, wpl(0, 16 + i, 1'b1));

    // Test 5: all masters hold AR to slave 0; grants rotate 0,1,2,3,4,0
    for (int m = 0; m < NM; m++) begin
      m_ar[m*64 +: 64] = arpl(m, 48'(m * 32'h80));
    end
    for (int k = 0; k < 6; k++) exp_ar[0].push_back(arpl(k % 5, 48'((k % 5) * 32'h80)));
    m_arvalid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_ar_rotation", 80'(m_arready), 80'(1) << (k % 5));
      @(posedge clk);
    end
    #1;
    m_arvalid = '0;
    repeat (3) @(posedge clk); #1;

    // Test 6: reset in the middle of a burst
    s_awready[1] = 1'b0;
    s_wready[1]  = 1'b0;
    aw_send(0, 48'h40);
    w_beat(0, wpl(0, 0, 1'b0));
    chk("t6_pre_s_awvalid", 80'(s_awvalid[1]), 80'(1));
    chk("t6_pre_s_wvalid", 80'(s_wvalid[1]), 80'(1));
    m_awvalid[1] = 1'b1; m_aw[64 +: 64] = awpl(1, 48'h00);
    m_arvalid[1] = 1'b1; m_ar[64 +: 64] = arpl(1, 48'h00);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_s_awvalid", 80'(s_awvalid), 80'(0));
    chk("t6_rst_s_wvalid", 80'(s_wvalid), 80'(0));
    chk("t6_rst_s_arvalid", 80'(s_arvalid), 80'(0));
    chk("t6_rst_m_awready", 80'(m_awready), 80'(0));
    chk("t6_rst_m_arready", 80'(m_arready), 80'(0));
    chk("t6_rst_m_wready", 80'(m_wready), 80'(0));
    for (int s = 0; s < NS; s++) begin
      exp_aw[s].delete(); exp_w[s].delete(); exp_ar[s].delete();
    end
    m_awvalid = '0; m_arvalid = '0; m_wvalid = '0;
    s_awready = '1; s_wready = '1;
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    m_awvalid[0] = 1'b1; m_aw[0 +: 64]   = awpl(0, 48'h1C0);
    m_awvalid[2] = 1'b1; m_aw[128 +: 64] = awpl(2, 48'h140);
    exp_aw[1].push_back(awpl(0, 48'h1C0));
    exp_aw[1].push_back(awpl(2, 48'h140));
    @(negedge clk);
    chk("t6_rr_after_reset", 80'(m_awready), 80'(5'b00001));
    @(posedge clk); #1;
    m_awvalid[0] = 1'b0;
    @(negedge clk);
    chk("t6_second_grant_m2", 80'(m_awready[2]), 80'(1));
    @(posedge clk); #1;
    m_awvalid[2] = 1'b0;
    exp_w[1].push_back(wpl(0, 5, 1'b1));
    exp_w[1].push_back(wpl(2, 5, 1'b1));
    fork
      w_beat(2, wpl(2, 5, 1'b1));
      w_beat(0, wpl(0, 5, 1'b1));
    join

    // Drain and confirm every expected payload was delivered
    repeat (5) @(negedge clk);
    for (int s = 0; s < NS; s++) begin
      chk("end_aw_queue_empty", 80'(exp_aw[s].size()), 80'(0));
      chk("end_w_queue_empty", 80'(exp_w[s].size()), 80'(0));
      chk("end_ar_queue_empty", 80'(exp_ar[s].size()), 80'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
